mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the datapath request interface: services iREN (fetch) and dREN/dWEN (load/store).
// - Raises ihit/dhit after a fixed, programmable wait latency.
// - Holds a word-addressed RAM; sits between the pipeline's request side and the memory model used in simulation/FPGA.
// - One request serviced at a time; data side has priority over instruction side.
// PARAMETERS
// - LAT      2   wait cycles inserted before a hit (0..15)
// - DEPTH_W  10  log2 of RAM depth in 32-bit words
// PORTS
// - CLK     in   1   clock, rising edge
// - nRST    in   1   reset; asynchronous, active-low
// - iREN    in   1   instruction fetch request
// - iaddr   in   32  fetch byte address
// - ihit    out  1   fetch complete; one-cycle pulse
// - iload   out  32  fetched word; valid while ihit=1
// - dREN    in   1   data load request
// - dWEN    in   1   data store request
// - daddr   in   32  data byte address
// - dstore  in   32  store data
// - dhit    out  1   data access complete; one-cycle pulse
// - dload   out  32  loaded word; valid while dhit=1
// - merr    out  1   access error pulse (see CONFIGURATION)
// BEHAVIOUR
// - Reset (nRST=0, async):
//   - state=IDLE; ihit, dhit, merr=0; iload, dload=0; cnt=0.
//   - RAM contents are not cleared.
//   - A pending store is discarded.
// - Word index = addr[DEPTH_W+1:2]. Upper address bits are ignored, so addresses alias modulo 2^DEPTH_W words.
// - FSM states: IDLE, WAIT, ACK.
//   - IDLE: sample requests at the clock edge.
//     - If dWEN or dREN: capture side=D, op=(dWEN ? write : read), go to WAIT with cnt=LAT.
//     - Else if iREN: capture side=I, go to WAIT with cnt=LAT.
//     - Else stay in IDLE.
//   - WAIT: if cnt==0, go to ACK; else cnt-=1. WAIT therefore lasts LAT+1 cycles.
//   - Edge WAIT->ACK:
//     - Read: register RAM[idx] into dload/iload.
//     - Write: RAM[idx]<=dstore.
//   - ACK: hit of the captured side is 1 for exactly one cycle; next edge goes to IDLE unconditionally.
// - Latency: request first seen in IDLE at cycle 0 -> hit asserted in cycle LAT+2.
//   - Back-to-back requests: one IDLE bubble after each ACK.
// - Requester holds request, address and dstore stable until its hit.
// - Abort: if the captured request drops in WAIT, return to IDLE next edge. No hit, no write, loads unchanged.
//   - Captured request = dREN/dWEN for side D, iREN for side I.
// - Simultaneous iREN and dREN/dWEN in IDLE: data side wins. iREN stays pending and is serviced after the return to IDLE.
// - No preemption: a data request arriving during an I-side WAIT waits for that ACK.
// - dREN=1 and dWEN=1 together: treated as a write.
// - iload/dload hold their last value outside ACK. ihit and dhit are never 1 together.
// - Reset mid-WAIT: immediate IDLE; RAM unchanged.
// CONFIGURATION
// - MEM_ALIGN_CHECK_EN defined:
//   - In IDLE, a captured address with addr[1:0]!=0, or a request with dREN=1 and dWEN=1, takes the normal WAIT/ACK path.
//   - merr=1 during its ACK cycle, alongside the hit.
//   - No RAM write occurs; the load returns 32'h0.
// - MEM_ALIGN_CHECK_EN undefined:
//   - addr[1:0] is ignored; dREN&dWEN behaves as a write.
//   - merr is tied to 0.
// TESTING
// - LAT=2: store daddr=0x40, dstore=0xDEADBEEF -> dhit in cycle 4; then load 0x40 -> dload=0xDEADBEEF with dhit.
// - iREN (iaddr=0x0) and dREN (daddr=0x40) raised in the same cycle -> dhit first (cycle 4); ihit in cycle 9 with iload=RAM[0].
// - LAT=0: fetch -> ihit in cycle 2; hold iREN across ihit -> second ihit in cycle 5 (one-bubble spacing).
// - Drop dWEN after 1 WAIT cycle (LAT=3) -> no dhit, and RAM[idx] unchanged on a later read.
// - DEPTH_W=10: store 0x1111 at 0x0000_1004, load 0x0000_0004 -> 0x1111 (aliasing). nRST low mid-WAIT -> outputs 0, state IDLE.
// - With MEM_ALIGN_CHECK_EN: store to 0x42 -> dhit and merr together, RAM unchanged. Without the macro: merr stays 0, word 0x40 written.

Source files
------------

// File: rtl/mem_responder.sv
// Purpose: word-addressed RAM responder for the pipeline's fetch (I) and load/store (D) request ports.
// Latency: a request first seen in IDLE at cycle 0 gets its hit in cycle LAT+2, with one IDLE bubble after each ACK.
// Backpressure: one request at a time, D side wins over I side, and the requester holds its request until the hit.
// Optional MEM_ALIGN_CHECK_EN: misaligned addresses or dREN&dWEN give merr with the hit, no write, and load 0.
module mem_responder #(
    parameter int LAT     = 2,
    parameter int DEPTH_W = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        merr
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t             r_state, w_nxt_state;
    logic [3:0]         r_cnt, w_nxt_cnt;
    logic               r_side_d, w_nxt_side_d;
    logic               r_wr, w_nxt_wr;
    logic               r_err, w_nxt_err;
    logic [31:0]        r_iload, r_dload;
    logic [31:0]        r_mem [0:(1<<DEPTH_W)-1];

    logic               w_dreq;
    logic               w_req_live;
    logic               w_done;
    logic               w_mem_we;
    logic               w_new_err;
    logic [DEPTH_W-1:0] w_idx_i, w_idx_d;
    logic               w_unused_addr;

    assign w_dreq     = dREN | dWEN;
    // The captured side's request must stay up through WAIT, otherwise the access is abandoned.
    assign w_req_live = r_side_d ? w_dreq : iREN;
    assign w_done     = (r_state == ST_WAIT) && w_req_live && (r_cnt == 4'd0);
    assign w_mem_we   = w_done && r_side_d && r_wr && !r_err;
    assign w_idx_i    = iaddr[DEPTH_W+1:2];
    assign w_idx_d    = daddr[DEPTH_W+1:2];
    // Upper bits alias; low bits only matter to the alignment check.
    assign w_unused_addr = ^{iaddr[31:DEPTH_W+2], daddr[31:DEPTH_W+2], iaddr[1:0], daddr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign w_new_err = w_dreq ? ((daddr[1:0] != 2'b00) || (dREN && dWEN))
                              : (iaddr[1:0] != 2'b00);
`else
    assign w_new_err = 1'b0;
`endif

    // State register: FSM state plus the attributes captured when leaving IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_side_d <= 1'b0;
            r_wr     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_side_d <= w_nxt_side_d;
            r_wr     <= w_nxt_wr;
            r_err    <= w_nxt_err;
        end
    end

    // Next-state logic: arbitrate in IDLE, count down in WAIT, drop to IDLE on abort or after ACK.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_side_d = r_side_d;
        w_nxt_wr     = r_wr;
        w_nxt_err    = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_dreq) begin
                    w_nxt_state  = ST_WAIT;
                    w_nxt_cnt    = 4'(LAT);
                    w_nxt_side_d = 1'b1;
                    w_nxt_wr     = dWEN;
                    w_nxt_err    = w_new_err;
                end else if (iREN) begin
                    w_nxt_state  = ST_WAIT;
                    w_nxt_cnt    = 4'(LAT);
                    w_nxt_side_d = 1'b0;
                    w_nxt_wr     = 1'b0;
                    w_nxt_err    = w_new_err;
                end
            end
            ST_WAIT: begin
                if (!w_req_live) begin
                    w_nxt_state = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_nxt_state = ST_ACK;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: hits and the error flag are a pure function of being in ACK.
    always_comb begin
        ihit = (r_state == ST_ACK) && !r_side_d;
        dhit = (r_state == ST_ACK) && r_side_d;
`ifdef MEM_ALIGN_CHECK_EN
        merr = (r_state == ST_ACK) && r_err;
`else
        merr = 1'b0;
`endif
    end

    // RAM write on the WAIT->ACK edge; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_idx_d] <= dstore;
        end
    end

    // Read data registered on the WAIT->ACK edge and held until the next completed read.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_iload <= 32'h0;
            r_dload <= 32'h0;
        end else if (w_done) begin
            if (r_side_d) begin
                if (r_err) begin
                    r_dload <= 32'h0;
                end else if (!r_wr) begin
                    r_dload <= r_mem[w_idx_d];
                end
            end else begin
                r_iload <= r_err ? 32'h0 : r_mem[w_idx_i];
            end
        end
    end

    assign iload = r_iload;
    assign dload = r_dload;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'h0;
    logic [31:0] dstore = 32'h0;
    logic        dhit;
    logic [31:0] dload;
    logic        merr;

    typedef struct packed {
        logic        is_d;
        logic [31:0] dat;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'h0;
    logic [31:0] m_dload = 32'h0;
    logic [31:0] m_iload = 32'h0;
    logic        align_en;

    mem_responder #(.LAT(LAT), .DEPTH_W(10)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload), .merr(merr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 32'd1;

    // Monitor: every hit pops the oldest expectation and compares side, data, merr and cycle.
    always @(negedge CLK) begin
        if (nRST && (ihit || dhit)) begin
            exp_t e;
            exp_t a;
            checks++;
            a = '{is_d: dhit, dat: (dhit ? dload : iload), err: merr, cyc: cyc};
            if (ihit && dhit) begin
                errors++;
                $display("FAIL both_hits: ihit=%0b dhit=%0b required one-hot", ihit, dhit);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hit: is_d=%0b dat=%h cyc=%0d required no hit", a.is_d, a.dat, a.cyc);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL hit: got is_d=%0b dat=%h merr=%0b cyc=%0d required is_d=%0b dat=%h merr=%0b cyc=%0d",
                             a.is_d, a.dat, a.err, a.cyc, e.is_d, e.dat, e.err, e.cyc);
                end
            end
        end
    end

    task automatic wait_hit(input logic want_d);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge CLK); #1;
            if (want_d ? dhit : ihit) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no %s hit within 40 cycles, required one", want_d ? "d" : "i");
        end
    endtask

    // One data access: drive at cycle k, expect the hit in cycle k+LAT+2, release after the hit.
    task automatic d_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_load, input logic exp_err);
        @(posedge CLK); #1;
        dWEN = wr; dREN = rd; daddr = addr; dstore = data;
        sb_q.push_back('{is_d: 1'b1, dat: exp_load, err: exp_err, cyc: cyc + LAT + 2});
        wait_hit(1'b1);
        dWEN = 1'b0; dREN = 1'b0;
        m_dload = exp_load;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({ihit, dhit, merr, iload, dload} !== 67'h0) begin
            errors++;
            $display("FAIL %s: ihit=%0b dhit=%0b merr=%0b iload=%h dload=%h required all 0",
                     name, ihit, dhit, merr, iload, dload);
        end
    endtask

    initial begin
        logic [31:0] k;
`ifdef MEM_ALIGN_CHECK_EN
        align_en = 1'b1;
`else
        align_en = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1 check_idle_outputs("reset_state");
        nRST = 1'b1;

        // Store then load the same word.
        d_access(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, m_dload, 1'b0);
        d_access(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
        d_access(1'b1, 1'b0, 32'h0, 32'h12345678, m_dload, 1'b0);

        // Simultaneous I and D: D first at k+4, I after the bubble at k+9.
        @(posedge CLK); #1;
        k = cyc;
        iREN = 1'b1; iaddr = 32'h0; dREN = 1'b1; daddr = 32'h40;
        sb_q.push_back('{is_d: 1'b1, dat: 32'hDEADBEEF, err: 1'b0, cyc: k + LAT + 2});
        sb_q.push_back('{is_d: 1'b0, dat: 32'h12345678, err: 1'b0, cyc: k + 2*LAT + 5});
        wait_hit(1'b1);
        dREN = 1'b0;
        wait_hit(1'b0);
        iREN = 1'b0;
        m_dload = 32'hDEADBEEF; m_iload = 32'h12345678;

        // iREN held across ihit: back-to-back fetches spaced by one IDLE bubble.
        @(posedge CLK); #1;
        k = cyc;
        iREN = 1'b1; iaddr = 32'h40;
        sb_q.push_back('{is_d: 1'b0, dat: 32'hDEADBEEF, err: 1'b0, cyc: k + LAT + 2});
        sb_q.push_back('{is_d: 1'b0, dat: 32'hDEADBEEF, err: 1'b0, cyc: k + 2*LAT + 5});
        wait_hit(1'b0);
        wait_hit(1'b0);
        iREN = 1'b0;
        m_iload = 32'hDEADBEEF;

        // Abort: store dropped after one WAIT cycle must neither hit nor write.
        d_access(1'b1, 1'b0, 32'h80, 32'h0000AAAA, m_dload, 1'b0);
        @(posedge CLK); #1;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h0000BBBB;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        dWEN = 1'b0;
        repeat (8) @(posedge CLK);
        d_access(1'b0, 1'b1, 32'h80, 32'h0, 32'h0000AAAA, 1'b0);

        // Aliasing: 0x1004 and 0x0004 are the same word with DEPTH_W=10.
        d_access(1'b1, 1'b0, 32'h0000_1004, 32'h00001111, m_dload, 1'b0);
        d_access(1'b0, 1'b1, 32'h0000_0004, 32'h0, 32'h00001111, 1'b0);

        // Reset mid-WAIT: outputs clear at once, pending store discarded.
        @(posedge CLK); #1;
        dWEN = 1'b1; daddr = 32'h4; dstore = 32'h00002222;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1 check_idle_outputs("reset_mid_wait");
        dWEN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        m_dload = 32'h0; m_iload = 32'h0;
        d_access(1'b0, 1'b1, 32'h4, 32'h0, 32'h00001111, 1'b0);

        // Misaligned store to 0x42.
        if (align_en) begin
            d_access(1'b1, 1'b0, 32'h42, 32'h00005555, 32'h0, 1'b1);
            d_access(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
        end else begin
            d_access(1'b1, 1'b0, 32'h42, 32'h00005555, m_dload, 1'b0);
            d_access(1'b0, 1'b1, 32'h40, 32'h0, 32'h00005555, 1'b0);
        end

        // dREN and dWEN together.
        d_access(1'b1, 1'b0, 32'h8, 32'h00000066, m_dload, 1'b0);
        if (align_en) begin
            d_access(1'b1, 1'b1, 32'h8, 32'h00000077, 32'h0, 1'b1);
            d_access(1'b0, 1'b1, 32'h8, 32'h0, 32'h00000066, 1'b0);
        end else begin
            d_access(1'b1, 1'b1, 32'h8, 32'h00000077, m_dload, 1'b0);
            d_access(1'b0, 1'b1, 32'h8, 32'h0, 32'h00000077, 1'b0);
        end

        repeat (6) @(posedge CLK);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected hits missing, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
